// File: rtl/conv_linebuf_ctrl_if.sv
// Handshake and row-FIFO control bundle between the line-buffer sequencer,
// the pixel source, the row-FIFO bank and the downstream MAC array.
interface conv_linebuf_ctrl_if #(
   parameter int unsigned K     = 5,
   parameter int unsigned CNT_W = 8
);
   logic             start;
   logic             pix_valid;
   logic             out_ready;
   logic             pix_ready;
   logic [K-2:0]     fifo_full;
   logic [K-2:0]     fifo_empty;
   logic [K-2:0]     fifo_wr_en;
   logic [K-2:0]     fifo_rd_en;
   logic             win_valid;
   logic [CNT_W-1:0] win_row;
   logic [CNT_W-1:0] win_col;
   logic             busy;
   logic             frame_done;
   logic             err;

   modport slave (
      input  start, pix_valid, out_ready, fifo_full, fifo_empty,
      output pix_ready, fifo_wr_en, fifo_rd_en, win_valid, win_row, win_col,
             busy, frame_done, err
   );

   modport master (
      output start, pix_valid, out_ready, fifo_full, fifo_empty,
      input  pix_ready, fifo_wr_en, fifo_rd_en, win_valid, win_row, win_col,
             busy, frame_done, err
   );
endinterface

// File: rtl/conv_linebuf_ctrl.sv
// Line-buffer sequencer for a KxK convolution window over K-1 row FIFOs (K >= 3).
// Optional FIFO protocol checker enabled by defining LINEBUF_CHK_EN.
module conv_linebuf_ctrl #(
   parameter int unsigned IMG_W = 32,
   parameter int unsigned IMG_H = 32,
   parameter int unsigned K     = 5,
   parameter int unsigned CNT_W = 8
) (
   input logic                clk,
   input logic                rst_n,
   conv_linebuf_ctrl_if.slave ctrl_io
);
   localparam int NF = int'(K) - 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StStream = 2'd1;
   localparam logic [1:0] StDone   = 2'd2;

   localparam logic [CNT_W-1:0] LastRow   = CNT_W'(IMG_H - 1);
   localparam logic [CNT_W-1:0] LastCol   = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] WrLastRow = CNT_W'(IMG_H - 2);
   localparam logic [CNT_W-1:0] WinOff    = CNT_W'(K - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [NF-2:0]    chain_q, chain_d;
   logic             win_valid_q, win_valid_d;
   logic [CNT_W-1:0] win_row_q, win_col_q;

   logic             pix_ready;
   logic             accept;
   logic             wr0;
   logic [NF-1:0]    fifo_wr_en;
   logic [NF-1:0]    fifo_rd_en;

   always_comb begin
      pix_ready = (state_q == StStream) && ctrl_io.out_ready;
      accept    = ctrl_io.pix_valid && pix_ready;

      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      unique case (state_q)
         StIdle: begin
            if (ctrl_io.start) begin
               state_d = StStream;
               row_d   = '0;
               col_d   = '0;
            end
         end
         StStream: begin
            if (accept) begin
               if (col_q == LastCol) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
               end
               if (row_q == LastRow && col_q == LastCol) state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Row r feeds FIFO i once r > i; nothing is pushed during the final row.
   always_comb begin
      wr0 = accept && (row_q <= WrLastRow);
      for (int i = 0; i < NF; i++) begin
         fifo_rd_en[i] = accept && (row_q >= CNT_W'(i + 1));
      end
      for (int i = 0; i < NF - 1; i++) begin
         chain_d[i] = fifo_rd_en[i] && (row_q <= WrLastRow);
      end
      win_valid_d = accept && (row_q >= WinOff) && (col_q >= WinOff);
   end

   // FIFO data_out is registered on read, so onward writes lag the read by a cycle.
   assign fifo_wr_en = {chain_q, wr0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         row_q       <= '0;
         col_q       <= '0;
         chain_q     <= '0;
         win_valid_q <= 1'b0;
         win_row_q   <= '0;
         win_col_q   <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         chain_q     <= chain_d;
         win_valid_q <= win_valid_d;
         if (win_valid_d) begin
            win_row_q <= row_q - WinOff;
            win_col_q <= col_q - WinOff;
         end
      end
   end

   assign ctrl_io.pix_ready  = pix_ready;
   assign ctrl_io.fifo_wr_en = fifo_wr_en;
   assign ctrl_io.fifo_rd_en = fifo_rd_en;
   assign ctrl_io.win_valid  = win_valid_q;
   assign ctrl_io.win_row    = win_row_q;
   assign ctrl_io.win_col    = win_col_q;
   assign ctrl_io.busy       = (state_q != StIdle);
   assign ctrl_io.frame_done = (state_q == StDone);

`ifdef LINEBUF_CHK_EN
   logic err_q, err_d;
   logic viol;

   always_comb begin
      viol  = |((fifo_wr_en & ctrl_io.fifo_full) | (fifo_rd_en & ctrl_io.fifo_empty));
      err_d = err_q | viol;
      if (state_q == StIdle && ctrl_io.start) err_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign ctrl_io.err = err_q;
`else
   logic unused_fifo_flags;
   assign unused_fifo_flags = ^{ctrl_io.fifo_full, ctrl_io.fifo_empty};
   assign ctrl_io.err       = 1'b0;
`endif
endmodule

// File: tb/tb_conv_linebuf_ctrl.sv
// Self-checking bench for conv_linebuf_ctrl: vector table, directed corners and
// randomized handshakes against a pixel-index reference model and a FIFO-bank stand-in.
module tb_conv_linebuf_ctrl;
   localparam int IMG_W = 8;
   localparam int IMG_H = 6;
   localparam int K     = 5;
   localparam int CNT_W = 8;
   localparam int NF    = K - 1;
   localparam int DEPTH = IMG_W + 1;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int WIN_W = IMG_W - K + 1;
   localparam int NWIN  = (IMG_W - K + 1) * (IMG_H - K + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   conv_linebuf_ctrl_if #(.K(K), .CNT_W(CNT_W)) bus ();

   conv_linebuf_ctrl #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .K     (K),
      .CNT_W (CNT_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctrl_io (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit start, pv, ordy;
      bit busy, ready, wr0;
   } vec_t;
   vec_t tbl[8];

   int total = 0;
   int bad   = 0;

   // FIFO bank stand-in
   int occ[NF];
   bit force_empty0;

   // Reference model: frame status plus accepted-pixel index
   bit m_active, m_done, m_err;
   int m_n, m_prev;

   int win_seen;
   int cyc_g;
   int first_rd0_cyc, first_rd0_n, first_wr1_cyc, first_rd3_n, wr0_last_row;

   function automatic void check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic longint pack_outputs();
      return longint'({bus.pix_ready, bus.fifo_wr_en, bus.fifo_rd_en, bus.win_valid,
                       bus.win_row, bus.win_col, bus.busy, bus.frame_done, bus.err});
   endfunction

   task automatic drive_flags();
      for (int i = 0; i < NF; i++) begin
         bus.fifo_full[i]  = (occ[i] >= DEPTH);
         bus.fifo_empty[i] = (occ[i] == 0);
      end
      if (force_empty0 && m_active && m_n == IMG_W) bus.fifo_empty[0] = 1'b1;
   endtask

   task automatic model_reset();
      m_active = 0; m_done = 0; m_err = 0; m_n = 0; m_prev = -1;
      for (int i = 0; i < NF; i++) occ[i] = 0;
   endtask

   task automatic probes_reset();
      first_rd0_cyc = -1; first_rd0_n = -1; first_wr1_cyc = -1;
      first_rd3_n = -1; wr0_last_row = 0;
   endtask

   // One clock: inputs already applied at posedge+1; compare at negedge, update at posedge.
   task automatic cycle();
      logic [NF-1:0]    e_wr, e_rd, s_wr, s_rd;
      logic [CNT_W-1:0] e_row, e_col;
      bit e_ready, e_acc, e_win, viol, start_ok;
      int r, c, pr, pc;
      drive_flags();
      #4;
      e_ready = m_active && bus.out_ready;
      e_acc   = e_ready && bus.pix_valid;
      r = m_n / IMG_W;
      c = m_n % IMG_W;
      e_wr = '0;
      e_rd = '0;
      if (e_acc) begin
         e_wr[0] = (r <= IMG_H - 2);
         for (int i = 0; i < NF; i++) e_rd[i] = (r >= i + 1);
      end
      e_win = 0; e_row = '0; e_col = '0;
      if (m_prev >= 0) begin
         pr = m_prev / IMG_W;
         pc = m_prev % IMG_W;
         for (int i = 0; i < NF - 1; i++) e_wr[i+1] = (pr >= i + 1) && (pr <= IMG_H - 2);
         e_win = (pr >= K - 1) && (pc >= K - 1);
         if (e_win) begin
            e_row = CNT_W'(pr - (K - 1));
            e_col = CNT_W'(pc - (K - 1));
         end
      end
      check("pix_ready", bus.pix_ready, e_ready);
      check("busy", bus.busy, m_active || m_done);
      check("frame_done", bus.frame_done, m_done);
      check("fifo_wr_en", bus.fifo_wr_en, e_wr);
      check("fifo_rd_en", bus.fifo_rd_en, e_rd);
      check("win_valid", bus.win_valid, e_win);
      if (e_win) begin
         check("win_row", bus.win_row, e_row);
         check("win_col", bus.win_col, e_col);
      end
`ifdef LINEBUF_CHK_EN
      check("err", bus.err, m_err);
`else
      check("err", bus.err, 0);
`endif
      if (m_done) check("empty_at_done", bus.fifo_empty, {NF{1'b1}});
      if (bus.win_valid) begin
         check("win_order_row", bus.win_row, win_seen / WIN_W);
         check("win_order_col", bus.win_col, win_seen % WIN_W);
         win_seen++;
      end
      if (bus.fifo_rd_en[0] && first_rd0_cyc < 0) begin
         first_rd0_cyc = cyc_g; first_rd0_n = m_n;
      end
      if (bus.fifo_wr_en[1] && first_wr1_cyc < 0) first_wr1_cyc = cyc_g;
      if (bus.fifo_rd_en[NF-1] && first_rd3_n < 0) first_rd3_n = m_n;
      if (bus.fifo_wr_en[0] && m_active && m_n >= (IMG_H - 1) * IMG_W) wr0_last_row++;
      viol = |((e_wr & bus.fifo_full) | (e_rd & bus.fifo_empty));
      s_wr = bus.fifo_wr_en;
      s_rd = bus.fifo_rd_en;
      start_ok = !m_active && !m_done && bus.start;
      @(posedge clk);
      for (int i = 0; i < NF; i++) occ[i] += int'(s_wr[i]) - int'(s_rd[i]);
      m_done = 0;
      if (e_acc) begin
         m_prev = m_n;
         m_n++;
         if (m_n == NPIX) begin
            m_active = 0;
            m_done   = 1;
         end
      end else begin
         m_prev = -1;
      end
      if (start_ok) begin
         m_active = 1; m_n = 0; m_err = 0;
      end else begin
         m_err = m_err | viol;
      end
      cyc_g++;
      #1;
   endtask

   task automatic run_frame(input int mode, input int mid_start, input int rst_at,
                            input bit use_tbl);
      int cyc;
      bit fin;
      cyc = 0;
      fin = 0;
      win_seen = 0;
      if (use_tbl) begin
         for (int k = 0; k < 8; k++) begin
            bus.start     = tbl[k].start;
            bus.pix_valid = tbl[k].pv;
            bus.out_ready = tbl[k].ordy;
            #2;
            check("tbl_busy", bus.busy, tbl[k].busy);
            check("tbl_ready", bus.pix_ready, tbl[k].ready);
            check("tbl_wr0", bus.fifo_wr_en[0], tbl[k].wr0);
            cycle();
         end
      end
      while (!fin && cyc < 3000) begin
         bus.start = ((cyc == 0) && !use_tbl) || (cyc == mid_start);
         unique case (mode)
            0: begin bus.pix_valid = 1; bus.out_ready = 1; end
            1: begin bus.pix_valid = 1; bus.out_ready = cyc[0]; end
            default: begin
               bus.pix_valid = ($urandom_range(0, 3) != 0);
               bus.out_ready = $urandom_range(0, 1);
            end
         endcase
         if (rst_at >= 0 && m_active && m_n == rst_at) begin
            rst_n = 0;
            #1;
            check("async_reset_outputs", pack_outputs(), 0);
            model_reset();
            bus.start = 0;
            @(posedge clk);
            #1;
            rst_n = 1;
            return;
         end
         cycle();
         cyc++;
         if (!m_active && !m_done) fin = 1;
      end
      if (!fin) check("frame_timeout", 0, 1);
      check("win_count", win_seen, NWIN);
   endtask

   initial begin
      tbl[0] = '{start: 0, pv: 1, ordy: 1, busy: 0, ready: 0, wr0: 0};
      tbl[1] = '{start: 1, pv: 1, ordy: 1, busy: 0, ready: 0, wr0: 0};
      tbl[2] = '{start: 0, pv: 1, ordy: 1, busy: 1, ready: 1, wr0: 1};
      tbl[3] = '{start: 0, pv: 1, ordy: 0, busy: 1, ready: 0, wr0: 0};
      tbl[4] = '{start: 0, pv: 0, ordy: 1, busy: 1, ready: 1, wr0: 0};
      tbl[5] = '{start: 1, pv: 1, ordy: 1, busy: 1, ready: 1, wr0: 1};
      tbl[6] = '{start: 0, pv: 0, ordy: 0, busy: 1, ready: 0, wr0: 0};
      tbl[7] = '{start: 0, pv: 1, ordy: 1, busy: 1, ready: 1, wr0: 1};

      bus.start = 0; bus.pix_valid = 0; bus.out_ready = 0;
      force_empty0 = 0;
      cyc_g = 0;
      model_reset();
      probes_reset();
      drive_flags();
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", pack_outputs(), 0);
      rst_n = 1;

      repeat (10) begin
         bus.start = 0;
         bus.pix_valid = $urandom_range(0, 1);
         bus.out_ready = $urandom_range(0, 1);
         cycle();
      end

      run_frame(2, -1, -1, 1);

      probes_reset();
      run_frame(0, -1, -1, 0);
      check("first_rd0_pixel", first_rd0_n, IMG_W);
      check("wr1_lag", first_wr1_cyc - first_rd0_cyc, 1);
      check("first_rd3_row", first_rd3_n / IMG_W, NF);
      check("wr0_in_last_row", wr0_last_row, 0);

      run_frame(1, -1, -1, 0);
      run_frame(2, 20, -1, 0);
      run_frame(2, -1, 3 * IMG_W + 3, 0);
      run_frame(0, -1, -1, 0);

      force_empty0 = 1;
      run_frame(0, -1, -1, 0);
      force_empty0 = 0;
      bus.start = 0;
      cycle();
`ifdef LINEBUF_CHK_EN
      check("err_sticky_after_frame", bus.err, 1);
`else
      check("err_tied_low", bus.err, 0);
`endif
      run_frame(2, -1, -1, 0);
      check("err_after_restart", bus.err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
